vc_output_port: RTL
===================

VC_OUTPUT_PORT -- requirements
Module: vc_output_port

Interface
REQ-001 Parameter N_IN, default 4: number of input ports (2..8).
REQ-002 Parameter N_VC, default 2: number of virtual channels (1..4); VCW = max(1, clog2(N_VC)).
REQ-003 Parameter FLIT_W, default 32: flit payload width.
REQ-004 Parameter CREDITS, default 4: downstream buffer depth per VC (1..15); CW = clog2(CREDITS+1).
REQ-005 Parameter HP_ZERO, default 1: 1 means VC0 is highest priority, 0 means VC N_VC-1 is highest.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 arst  in  1  reset, synchronous, active-high.
REQ-008 in_valid_i  in  N_IN  per-input flit valid.
REQ-009 in_vc_i  in  N_IN*VCW  per-input VC id.
REQ-010 in_type_i  in  N_IN*2  per-input flit type: 00 head, 01 body, 10 tail, 11 single (head+tail).
REQ-011 in_data_i  in  N_IN*FLIT_W  per-input payload.
REQ-012 in_ready_o  out  N_IN  flit accepted this cycle (combinational, one-hot or zero).
REQ-013 out_valid_o/out_vc_o/out_type_o/out_data_o  out  1/VCW/2/FLIT_W  registered output flit.
REQ-014 credit_i  in  N_VC  per-VC one-cycle credit-return pulse from downstream.
REQ-015 credit_err_o  out  1  sticky credit-overflow flag.

Function
REQ-016 Per VC v, input i is eligible when in_valid_i[i], in_vc_i[i]==v, and: if VC v is locked, i equals lock owner; if unlocked, type is head or single.
REQ-017 Per VC, a round-robin arbiter picks among eligible inputs, starting search at rr_ptr[v].
REQ-018 VC v is requestable when at least one input is eligible and credit[v] > 0.
REQ-019 Among requestable VCs, fixed priority per HP_ZERO selects exactly one winner VC per cycle.
REQ-020 in_ready_o asserts only for the winning input of the winning VC; that flit is accepted that cycle.
REQ-021 An accepted flit appears on out_* on the next cycle with out_valid_o=1 for exactly one cycle; out_valid_o=0 otherwise, and out_* hold their last values.
REQ-022 Latency: acceptance at cycle t -> out_valid_o at t+1; throughput is one flit per cycle.
REQ-023 Accepting a head flit locks its VC to that input; accepting a tail clears the lock; a single flit never locks.
REQ-024 On accepting a tail or single flit, rr_ptr[v] becomes (winner+1) mod N_IN; otherwise rr_ptr is unchanged.
REQ-025 credit[v] decrements on acceptance for VC v and increments on credit_i[v]; if both occur in the same cycle, credit[v] is unchanged.
REQ-026 A credit_i[v] pulse with credit[v]==CREDITS and no simultaneous send is ignored and sets credit_err_o until reset.
REQ-027 A body or tail flit on an unlocked VC, or from a non-owner on a locked VC, is never accepted and stalls.
REQ-028 Lower-priority VCs are served in any cycle where higher VCs are not requestable; flits of different VCs may interleave.

Reset
REQ-029 While arst=1 at a clock edge: out_valid_o=0, out_vc_o=0, out_type_o=0, out_data_o=0, all credit[v]=CREDITS, all locks cleared, rr_ptr=0, credit_err_o=0.
REQ-030 in_ready_o is forced to 0 while arst=1.
REQ-031 Reset mid-packet discards the lock; the next head on that VC arbitrates normally.

Configuration
REQ-032 Macro VC_OUTPUT_PERF_CNT_EN: when defined, the block adds output flit_cnt_o (N_VC*16), a per-VC wrap-around count of accepted flits, cleared by reset.
REQ-033 Without VC_OUTPUT_PERF_CNT_EN, the flit_cnt_o port and its counters are absent, and all other behaviour is identical.

Verification
REQ-034 Scenario 1: after reset, input 0 sends a single flit on VC0 with data 0xA5 -> in_ready_o=0001 in the same cycle; next cycle out_valid_o=1, out_data_o=0xA5, out_type_o=11; credit[0]=3.
REQ-035 Scenario 2: inputs 1 and 2 each send a 3-flit packet on VC0 in the same cycle -> input 1 sends all 3 flits back-to-back, then input 2 sends its 3 flits; no interleaving.
REQ-036 Scenario 3: with HP_ZERO=1, input 0 sends on VC1 and input 3 sends on VC0 in the same cycle -> VC0 wins first; VC1 flits fill cycles where VC0 is idle.
REQ-037 Scenario 4: send 4 flits on VC0 with no credit_i -> the 5th flit stalls with in_ready_o=0; one credit_i[0] pulse -> the flit is accepted the next cycle.
REQ-038 Scenario 5: at credit[0]=4, pulse credit_i[0] -> credit_err_o=1 and stays 1; assert arst -> credit_err_o=0 and credit[0]=4.
REQ-039 Scenario 6: assert arst after the head and 1 body of a 4-flit packet -> lock cleared; a head from another input on the same VC is then accepted.

Source files
------------

// File: rtl/vc_output_port_if.sv
// vc_output_port_if -- flit bus between the input side, the output port and
// the downstream credit return.
//
// Parameters : N_IN, N_VC, FLIT_W (VCW derived as max(1, clog2(N_VC)))
// Signals    : in_valid_i/in_vc_i/in_type_i/in_data_i  per-input offered flit
//              in_ready_o                              per-input accept strobe
//              out_valid_o/out_vc_o/out_type_o/out_data_o  registered output flit
//              credit_i                                per-VC credit return pulse
//              credit_err_o                            sticky credit overflow
// Modports   : slave  = the output port itself, master = whoever drives it.
//
// Handshake: input i transfers a flit in a cycle exactly when in_valid_i[i]
// and in_ready_o[i] are both 1 at the rising edge. in_ready_o is combinational
// and may depend on in_valid_i; a source must not wait for in_ready_o before
// raising in_valid_i, and must hold its flit stable until it is accepted.
// out_valid_o is a one-cycle pulse per flit with no backpressure; flow
// control on the output side is purely credit based.
interface vc_output_port_if #(
  parameter int N_IN   = 4,
  parameter int N_VC   = 2,
  parameter int FLIT_W = 32
);
  localparam int VCW = (N_VC > 1) ? $clog2(N_VC) : 1;

  logic [N_IN-1:0]        in_valid_i;
  logic [N_IN*VCW-1:0]    in_vc_i;
  logic [N_IN*2-1:0]      in_type_i;
  logic [N_IN*FLIT_W-1:0] in_data_i;
  logic [N_IN-1:0]        in_ready_o;
  logic                   out_valid_o;
  logic [VCW-1:0]         out_vc_o;
  logic [1:0]             out_type_o;
  logic [FLIT_W-1:0]      out_data_o;
  logic [N_VC-1:0]        credit_i;
  logic                   credit_err_o;

  modport slave (
    input  in_valid_i, in_vc_i, in_type_i, in_data_i, credit_i,
    output in_ready_o, out_valid_o, out_vc_o, out_type_o, out_data_o, credit_err_o
  );

  modport master (
    output in_valid_i, in_vc_i, in_type_i, in_data_i, credit_i,
    input  in_ready_o, out_valid_o, out_vc_o, out_type_o, out_data_o, credit_err_o
  );
endinterface

// File: rtl/vc_output_port.sv
// vc_output_port -- one router output port shared by N_IN inputs over N_VC
// virtual channels with wormhole locking and per-VC credit flow control.
//
// Ports : clk          rising-edge clock
//         arst         synchronous active-high reset
//         bus          vc_output_port_if.slave (flit inputs, ready strobes,
//                      registered output flit, credit return, credit error)
//         flit_cnt_o   N_VC x 16-bit accepted-flit counters, only present when
//                      VC_OUTPUT_PERF_CNT_EN is defined
//
// Flit types: 00 head, 01 body, 10 tail, 11 single (head+tail).
// Each VC has a round-robin input arbiter; the VCs then compete under fixed
// priority (HP_ZERO=1: VC0 highest, else VC N_VC-1 highest). One flit moves
// per cycle and appears on out_* one cycle after acceptance.
module vc_output_port #(
  parameter int N_IN    = 4,
  parameter int N_VC    = 2,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4,
  parameter int HP_ZERO = 1
) (
  input  logic               clk,
  input  logic               arst,
  vc_output_port_if.slave    bus
`ifdef VC_OUTPUT_PERF_CNT_EN
  ,
  output logic [N_VC*16-1:0] flit_cnt_o
`endif
);
  localparam int VCW = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int IW  = $clog2(N_IN);

  // Per-VC state
  logic [CW-1:0]   credit   [N_VC];
  logic [N_VC-1:0] lock_vld;
  logic [IW-1:0]   lock_own [N_VC];
  logic [IW-1:0]   rr_ptr   [N_VC];

  // Arbitration results
  logic [N_IN-1:0]   elig [N_VC];
  logic [IW-1:0]     pick [N_VC];
  logic [N_VC-1:0]   req;
  logic              win_any;
  logic [VCW-1:0]    win_vc;
  logic [IW-1:0]     win_in;
  logic [1:0]        win_type;
  logic [FLIT_W-1:0] win_data;
  logic              accept;

  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      logic found;
      elig[v] = '0;
      pick[v] = '0;
      found   = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        logic [1:0] typ;
        typ = bus.in_type_i[2*i +: 2];
        // A locked VC only listens to its owner; an unlocked VC only to
        // flits that may open a packet.
        elig[v][i] = bus.in_valid_i[i] && (bus.in_vc_i[VCW*i +: VCW] == VCW'(v)) &&
                     (lock_vld[v] ? (lock_own[v] == IW'(i))
                                  : (typ == 2'b00 || typ == 2'b11));
      end
      // Round-robin: first eligible input at or after rr_ptr, wrapping.
      for (int k = 0; k < N_IN; k++) begin
        int idx;
        logic [IW-1:0] idx_b;
        idx = int'(rr_ptr[v]) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        idx_b = IW'(idx);
        if (!found && elig[v][idx_b]) begin
          found   = 1'b1;
          pick[v] = idx_b;
        end
      end
      req[v] = found && (credit[v] != '0);
    end

    // Walk from lowest to highest priority so the highest requester wins.
    win_any = 1'b0;
    win_vc  = '0;
    win_in  = '0;
    for (int v = N_VC - 1; v >= 0; v--) begin
      int vv;
      vv = (HP_ZERO != 0) ? v : (N_VC - 1 - v);
      if (req[vv]) begin
        win_any = 1'b1;
        win_vc  = VCW'(vv);
        win_in  = pick[vv];
      end
    end

    accept   = win_any && !arst;
    win_type = '0;
    win_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      bus.in_ready_o[i] = accept && (win_in == IW'(i));
      if (win_in == IW'(i)) begin
        win_type = bus.in_type_i[2*i +: 2];
        win_data = bus.in_data_i[FLIT_W*i +: FLIT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      bus.out_valid_o  <= 1'b0;
      bus.out_vc_o     <= '0;
      bus.out_type_o   <= '0;
      bus.out_data_o   <= '0;
      bus.credit_err_o <= 1'b0;
      lock_vld         <= '0;
      for (int v = 0; v < N_VC; v++) begin
        credit[v]   <= CW'(CREDITS);
        lock_own[v] <= '0;
        rr_ptr[v]   <= '0;
      end
    end else begin
      bus.out_valid_o <= accept;
      if (accept) begin
        bus.out_vc_o   <= win_vc;
        bus.out_type_o <= win_type;
        bus.out_data_o <= win_data;
        case (win_type)
          2'b00: begin
            lock_vld[win_vc] <= 1'b1;
            lock_own[win_vc] <= win_in;
          end
          2'b10: begin
            lock_vld[win_vc] <= 1'b0;
            rr_ptr[win_vc]   <= (win_in == IW'(N_IN - 1)) ? '0 : win_in + IW'(1);
          end
          2'b11: rr_ptr[win_vc] <= (win_in == IW'(N_IN - 1)) ? '0 : win_in + IW'(1);
          default: ;
        endcase
      end
      for (int v = 0; v < N_VC; v++) begin
        logic send;
        send = accept && (win_vc == VCW'(v));
        case ({send, bus.credit_i[v]})
          2'b10: credit[v] <= credit[v] - CW'(1);
          2'b01: begin
            // A return into a full counter can only be a downstream bug:
            // drop it and flag it.
            if (credit[v] == CW'(CREDITS)) bus.credit_err_o <= 1'b1;
            else                           credit[v] <= credit[v] + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef VC_OUTPUT_PERF_CNT_EN
  logic [15:0] flit_cnt [N_VC];

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < N_VC; v++) flit_cnt[v] <= '0;
    end else if (accept) begin
      flit_cnt[win_vc] <= flit_cnt[win_vc] + 16'd1;
    end
  end

  always_comb begin
    flit_cnt_o = '0;
    for (int v = 0; v < N_VC; v++) flit_cnt_o[16*v +: 16] = flit_cnt[v];
  end
`endif

endmodule
